// File: rtl/match_controller_pkg.sv
// Shared definitions for the sniffer packet-match controller.
package sniffer_pkg;

   // Controller state encoding; value 3'd7 is unused and recovers to IDLE.
   typedef enum logic [2:0] {
      LOAD_CFG = 3'd0,
      IDLE     = 3'd1,
      COMPARE  = 3'd2,
      SETTLE   = 3'd3,
      EVALUATE = 3'd4,
      STORE    = 3'd5,
      DROP     = 3'd6
   } mc_state_t;

   // Default comparator channel assignment.
   localparam int CH_PORT = 0;
   localparam int CH_IP   = 1;
   localparam int CH_MAC  = 2;
   localparam int CH_URL  = 3;

   // Settle counter width; covers the full 1..255 settle range.
   localparam int SETTLE_W = 8;

endpackage

// File: rtl/match_controller_if.sv
// MAC framing, comparator, Avalon configuration and statistics bundle.
interface match_controller_if #(
   parameter int NUM_CH   = 4,
   parameter int CNT_W    = 64,
   parameter int WEIGHT_W = 4,
   parameter int SCORE_W  = WEIGHT_W + $clog2(NUM_CH + 1)
);
   // Comparator and MAC side
   logic [NUM_CH-1:0]          match;
   logic                       sop;
   logic                       eop;
   logic                       error;
   logic                       valid;
   logic                       ready;
   // Avalon configuration side
   logic                       update_req;
   logic                       update_done;
   logic [NUM_CH*WEIGHT_W-1:0] weights_in;
   logic [SCORE_W-1:0]         threshold_in;
   logic                       clr_stats;
   // Controller outputs
   logic                       cfg_req;
   logic                       clear;
   logic                       inc_addr;
   logic                       busy;
   logic [NUM_CH*CNT_W-1:0]    hits;
   logic [CNT_W-1:0]           pkt_count;
   logic [CNT_W-1:0]           qual_count;
   logic [CNT_W-1:0]           err_count;

   // Controller view
   modport slave (
      input  match, sop, eop, error, valid, ready,
      input  update_req, update_done, weights_in, threshold_in, clr_stats,
      output cfg_req, clear, inc_addr, busy,
      output hits, pkt_count, qual_count, err_count
   );

   // Environment view (MAC, comparators, Avalon slave)
   modport master (
      output match, sop, eop, error, valid, ready,
      output update_req, update_done, weights_in, threshold_in, clr_stats,
      input  cfg_req, clear, inc_addr, busy,
      input  hits, pkt_count, qual_count, err_count
   );
endinterface

// File: rtl/match_controller_sat_counter.sv
// Saturating statistics counter with synchronous clear; clear beats increment.
module sat_counter #(
   parameter int W = 64
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] count
);
   logic [W-1:0] count_q;
   logic [W-1:0] count_d;

   // Next count: clear first, then increment unless already at all-ones.
   always_comb begin
      count_d = count_q;
      if (clr) begin
         count_d = '0;
      end else if (inc && (count_q != {W{1'b1}})) begin
         count_d = count_q + W'(1);
      end else begin
         count_d = count_q;
      end
   end

   // Count register.
   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;
endmodule

// File: rtl/match_controller.sv
// Packet-match controller: frames MAC packets, waits for the comparator
// pipeline to settle, scores weighted match flags and requests stores.
module match_controller
   import sniffer_pkg::*;
#(
   parameter int NUM_CH        = 4,
   parameter int CNT_W         = 64,
   parameter int WEIGHT_W      = 4,
   parameter int SETTLE_CYCLES = 4,
   parameter int SCORE_W       = WEIGHT_W + $clog2(NUM_CH + 1)
) (
   input  logic               clk,
   input  logic               rst,
   match_controller_if.slave  bus
);
   localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(SETTLE_CYCLES - 1);

   mc_state_t                  state_q, state_d;
   logic [SETTLE_W-1:0]        settle_q, settle_d;
   logic [NUM_CH*WEIGHT_W-1:0] weights_q, weights_d;
   logic [SCORE_W-1:0]         thr_q, thr_d;
   logic                       cfg_req_q, cfg_req_d;
   logic                       clear_q, clear_d;
   logic                       inc_addr_q, inc_addr_d;
   logic                       busy_q, busy_d;

   logic                       beat_s;
   logic [SCORE_W-1:0]         score_s;
   logic                       err_inc_s;
   logic                       pkt_inc_s;
   logic                       qual_inc_s;
   logic [NUM_CH-1:0]          hit_inc_s;
   logic [NUM_CH*CNT_W-1:0]    hits_s;
   logic [CNT_W-1:0]           pkt_cnt_s;
   logic [CNT_W-1:0]           qual_cnt_s;
   logic [CNT_W-1:0]           err_cnt_s;

   assign beat_s = bus.valid & bus.ready;

   // Weighted score of the current match flags, summed at full score width.
   always_comb begin
      score_s = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (bus.match[i]) begin
            score_s = score_s + SCORE_W'(weights_q[i*WEIGHT_W +: WEIGHT_W]);
         end else begin
            score_s = score_s;
         end
      end
   end

   // Next-state, settle counter, configuration latch and error strobe.
   always_comb begin
      state_d   = state_q;
      settle_d  = settle_q;
      weights_d = weights_q;
      thr_d     = thr_q;
      err_inc_s = 1'b0;
      case (state_q)
         LOAD_CFG: begin
            if (bus.update_done) begin
               weights_d = bus.weights_in;
               thr_d     = bus.threshold_in;
               state_d   = IDLE;
            end else begin
               state_d   = LOAD_CFG;
            end
         end
         IDLE: begin
            if (bus.update_req) begin
               state_d = LOAD_CFG;
            end else if (beat_s && bus.sop) begin
               if (bus.eop) begin
                  state_d  = SETTLE;
                  settle_d = SETTLE_LOAD;
               end else begin
                  state_d  = COMPARE;
               end
            end else begin
               state_d = IDLE;
            end
         end
         COMPARE: begin
            if (bus.error) begin
               state_d   = DROP;
               err_inc_s = 1'b1;
            end else if (beat_s && bus.sop && !bus.eop) begin
               // A new packet started before this one ended.
               state_d   = DROP;
               err_inc_s = 1'b1;
            end else if (beat_s && bus.eop) begin
               state_d   = SETTLE;
               settle_d  = SETTLE_LOAD;
            end else begin
               state_d   = COMPARE;
            end
         end
         SETTLE: begin
            if (settle_q == {SETTLE_W{1'b0}}) begin
               state_d  = EVALUATE;
            end else begin
               settle_d = settle_q - SETTLE_W'(1);
               state_d  = SETTLE;
            end
         end
         EVALUATE: begin
            if (score_s >= thr_q) begin
               state_d = STORE;
            end else begin
               state_d = IDLE;
            end
         end
         STORE: begin
            state_d = IDLE;
         end
         DROP: begin
            if (beat_s && bus.eop) begin
               state_d = IDLE;
            end else begin
               state_d = DROP;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Moore output decode from the next state so outputs register with it.
   always_comb begin
      cfg_req_d  = 1'b0;
      clear_d    = 1'b0;
      inc_addr_d = 1'b0;
      busy_d     = 1'b1;
      case (state_d)
         LOAD_CFG: begin
            cfg_req_d = 1'b1;
            clear_d   = 1'b1;
         end
         IDLE: begin
            clear_d   = 1'b1;
            busy_d    = 1'b0;
         end
         STORE: begin
            inc_addr_d = 1'b1;
         end
         COMPARE, SETTLE, EVALUATE, DROP: begin
            clear_d   = 1'b0;
         end
         default: begin
            clear_d   = 1'b1;
            busy_d    = 1'b0;
         end
      endcase
   end

   // Controller state, configuration and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= LOAD_CFG;
         settle_q   <= '0;
         weights_q  <= '0;
         thr_q      <= '0;
         cfg_req_q  <= 1'b1;
         clear_q    <= 1'b0;
         inc_addr_q <= 1'b0;
         busy_q     <= 1'b1;
      end else begin
         state_q    <= state_d;
         settle_q   <= settle_d;
         weights_q  <= weights_d;
         thr_q      <= thr_d;
         cfg_req_q  <= cfg_req_d;
         clear_q    <= clear_d;
         inc_addr_q <= inc_addr_d;
         busy_q     <= busy_d;
      end
   end

   // Statistics increments keyed off the current state.
   always_comb begin
      pkt_inc_s  = (state_q == EVALUATE);
      qual_inc_s = (state_q == STORE);
      hit_inc_s  = '0;
      if (state_q == EVALUATE) begin
         hit_inc_s = bus.match;
      end else begin
         hit_inc_s = '0;
      end
   end

   for (genvar g = 0; g < NUM_CH; g++) begin : g_hit
      sat_counter #(.W(CNT_W)) u_hit (
         .clk   (clk),
         .rst   (rst),
         .clr   (bus.clr_stats),
         .inc   (hit_inc_s[g]),
         .count (hits_s[g*CNT_W +: CNT_W])
      );
   end

   sat_counter #(.W(CNT_W)) u_pkt (
      .clk (clk), .rst (rst), .clr (bus.clr_stats), .inc (pkt_inc_s),  .count (pkt_cnt_s)
   );
   sat_counter #(.W(CNT_W)) u_qual (
      .clk (clk), .rst (rst), .clr (bus.clr_stats), .inc (qual_inc_s), .count (qual_cnt_s)
   );
   sat_counter #(.W(CNT_W)) u_err (
      .clk (clk), .rst (rst), .clr (bus.clr_stats), .inc (err_inc_s),  .count (err_cnt_s)
   );

   assign bus.cfg_req    = cfg_req_q;
   assign bus.clear      = clear_q;
   assign bus.inc_addr   = inc_addr_q;
   assign bus.busy       = busy_q;
   assign bus.hits       = hits_s;
   assign bus.pkt_count  = pkt_cnt_s;
   assign bus.qual_count = qual_cnt_s;
   assign bus.err_count  = err_cnt_s;
endmodule

// File: tb/tb_match_controller.sv
// Directed bench for match_controller: default 64-bit build plus a 4-bit
// counter build driven with identical stimulus.
module tb_match_controller;
   import sniffer_pkg::*;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] match;
   logic       sop, eop, error, valid, ready;
   logic       update_req, update_done, clr_stats;
   logic [15:0] weights_in;
   logic [6:0] threshold_in;

   int n_tests = 0;
   int n_fail  = 0;

   match_controller_if #(.NUM_CH(4), .CNT_W(64), .WEIGHT_W(4)) bus0 ();
   match_controller_if #(.NUM_CH(4), .CNT_W(4),  .WEIGHT_W(4)) bus1 ();

   assign bus0.match = match;        assign bus1.match = match;
   assign bus0.sop = sop;            assign bus1.sop = sop;
   assign bus0.eop = eop;            assign bus1.eop = eop;
   assign bus0.error = error;        assign bus1.error = error;
   assign bus0.valid = valid;        assign bus1.valid = valid;
   assign bus0.ready = ready;        assign bus1.ready = ready;
   assign bus0.update_req = update_req;     assign bus1.update_req = update_req;
   assign bus0.update_done = update_done;   assign bus1.update_done = update_done;
   assign bus0.weights_in = weights_in;     assign bus1.weights_in = weights_in;
   assign bus0.threshold_in = threshold_in; assign bus1.threshold_in = threshold_in;
   assign bus0.clr_stats = clr_stats;       assign bus1.clr_stats = clr_stats;

   match_controller #(.NUM_CH(4), .CNT_W(64), .WEIGHT_W(4), .SETTLE_CYCLES(4)) dut0 (
      .clk (clk), .rst (rst), .bus (bus0.slave)
   );
   match_controller #(.NUM_CH(4), .CNT_W(4), .WEIGHT_W(4), .SETTLE_CYCLES(4)) dut1 (
      .clk (clk), .rst (rst), .bus (bus1.slave)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          n;
      logic [3:0]  m;
      logic        st;
      logic [63:0] pkt;
      logic [63:0] qual;
      logic [63:0] h0, h1, h2, h3;
   } vec_t;
   vec_t tbl[7];

   function automatic logic [63:0] hit0(input int i);
      return bus0.hits[i*64 +: 64];
   endfunction

   function automatic logic [63:0] hit1(input int i);
      return 64'(bus1.hits[i*4 +: 4]);
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Sends an n-beat packet with flags m, then waits until EVALUATE is current.
   task automatic to_eval(input int n, input logic [3:0] m);
      match = m;
      for (int b = 0; b < n; b++) begin
         valid = 1'b1; ready = 1'b1;
         sop = (b == 0); eop = (b == n - 1);
         tick();
      end
      valid = 1'b0; sop = 1'b0; eop = 1'b0;
      for (int k = 0; k < 4; k++) tick();
   endtask

   task automatic beat(input logic s, input logic e, input logic er);
      valid = 1'b1; ready = 1'b1; sop = s; eop = e; error = er;
      tick();
      valid = 1'b0; sop = 1'b0; eop = 1'b0; error = 1'b0;
   endtask

   initial begin
      // weights {url=4, mac=1, ip=2, port=2}, threshold 4
      tbl[0] = '{8, 4'b0011, 1'b1, 64'd1, 64'd1, 64'd1, 64'd1, 64'd0, 64'd0};
      tbl[1] = '{3, 4'b0100, 1'b0, 64'd2, 64'd1, 64'd1, 64'd1, 64'd1, 64'd0};
      tbl[2] = '{1, 4'b1000, 1'b1, 64'd3, 64'd2, 64'd1, 64'd1, 64'd1, 64'd1};
      tbl[3] = '{2, 4'b0000, 1'b0, 64'd4, 64'd2, 64'd1, 64'd1, 64'd1, 64'd1};
      tbl[4] = '{5, 4'b1111, 1'b1, 64'd5, 64'd3, 64'd2, 64'd2, 64'd2, 64'd2};
      tbl[5] = '{4, 4'b0110, 1'b0, 64'd6, 64'd3, 64'd2, 64'd3, 64'd3, 64'd2};
      tbl[6] = '{2, 4'b0101, 1'b0, 64'd7, 64'd3, 64'd3, 64'd3, 64'd4, 64'd2};

      rst = 1'b1; match = '0; sop = 1'b0; eop = 1'b0; error = 1'b0;
      valid = 1'b0; ready = 1'b0; update_req = 1'b0; update_done = 1'b0;
      clr_stats = 1'b0; weights_in = '0; threshold_in = '0;
      tick(); tick();
      chk("rst_cfg_req", bus0.cfg_req, 1);
      chk("rst_clear", bus0.clear, 0);
      chk("rst_busy", bus0.busy, 1);
      chk("rst_inc_addr", bus0.inc_addr, 0);
      rst = 1'b0;
      tick();
      chk("load_clear", bus0.clear, 1);
      chk("load_cfg_req", bus0.cfg_req, 1);

      weights_in = {4'd4, 4'd1, 4'd2, 4'd2};
      threshold_in = 7'd4;
      update_done = 1'b1;
      tick();
      update_done = 1'b0;
      chk("cfg_req_fall", bus0.cfg_req, 0);
      chk("idle_busy", bus0.busy, 0);
      chk("init_pkt", bus0.pkt_count, 0);
      chk("init_qual", bus0.qual_count, 0);
      chk("init_err", bus0.err_count, 0);
      chk("init_hits", bus0.hits[63:0], 0);

      // Table-driven packets
      for (int v = 0; v < 7; v++) begin
         to_eval(tbl[v].n, tbl[v].m);
         chk("pkt_before_eval", bus0.pkt_count, tbl[v].pkt - 64'd1);
         chk("busy_eval", bus0.busy, 1);
         tick();
         chk("pkt_count", bus0.pkt_count, tbl[v].pkt);
         chk("inc_addr", bus0.inc_addr, 64'(tbl[v].st));
         tick();
         chk("inc_addr_off", bus0.inc_addr, 0);
         chk("qual_count", bus0.qual_count, tbl[v].qual);
         chk("busy_done", bus0.busy, 0);
         chk("hits_port", hit0(CH_PORT), tbl[v].h0);
         chk("hits_ip", hit0(CH_IP), tbl[v].h1);
         chk("hits_mac", hit0(CH_MAC), tbl[v].h2);
         chk("hits_url", hit0(CH_URL), tbl[v].h3);
         match = '0;
      end

      // Error mid-packet, repeated error in DROP, eop two beats later
      match = 4'b1111;
      beat(1'b1, 1'b0, 1'b0);
      beat(1'b0, 1'b0, 1'b0);
      beat(1'b0, 1'b0, 1'b1);
      chk("err_first", bus0.err_count, 1);
      chk("drop_busy", bus0.busy, 1);
      beat(1'b0, 1'b0, 1'b1);
      beat(1'b0, 1'b1, 1'b0);
      chk("drop_exit", bus0.busy, 0);
      chk("err_once", bus0.err_count, 1);
      for (int k = 0; k < 6; k++) begin
         chk("drop_no_store", bus0.inc_addr, 0);
         tick();
      end
      chk("err_pkt_same", bus0.pkt_count, 7);
      match = '0;

      // Missing eop: second sop before eop
      beat(1'b1, 1'b0, 1'b0);
      beat(1'b0, 1'b0, 1'b0);
      beat(1'b1, 1'b0, 1'b0);
      chk("missing_eop_err", bus0.err_count, 2);
      beat(1'b0, 1'b0, 1'b0);
      chk("missing_eop_drop", bus0.busy, 1);
      beat(1'b0, 1'b1, 1'b0);
      chk("missing_eop_idle", bus0.busy, 0);
      chk("missing_eop_pkt", bus0.pkt_count, 7);
      to_eval(3, 4'b0011);
      tick();
      chk("after_drop_pkt", bus0.pkt_count, 8);
      chk("after_drop_store", bus0.inc_addr, 1);
      tick();
      chk("after_drop_qual", bus0.qual_count, 4);
      match = '0;

      // update_req wins over a coincident sop beat; threshold 0 qualifies all
      update_req = 1'b1;
      beat(1'b1, 1'b0, 1'b0);
      update_req = 1'b0;
      chk("upd_cfg_req", bus0.cfg_req, 1);
      tick(); tick();
      chk("upd_hold", bus0.cfg_req, 1);
      weights_in = '0; threshold_in = 7'd0; update_done = 1'b1;
      tick();
      update_done = 1'b0;
      chk("upd_done", bus0.cfg_req, 0);
      to_eval(2, 4'b0000);
      tick();
      chk("thr0_pkt", bus0.pkt_count, 9);
      chk("thr0_store", bus0.inc_addr, 1);
      tick();
      chk("thr0_qual", bus0.qual_count, 5);
      update_req = 1'b1;
      tick();
      update_req = 1'b0;
      weights_in = {4'd4, 4'd1, 4'd2, 4'd2}; threshold_in = 7'd4; update_done = 1'b1;
      tick();
      update_done = 1'b0;

      // Statistics clear, then saturation on the 4-bit build
      clr_stats = 1'b1;
      tick();
      clr_stats = 1'b0;
      chk("clr_pkt", bus0.pkt_count, 0);
      chk("clr_err", bus0.err_count, 0);
      chk("clr_state", bus0.busy, 0);
      for (int k = 0; k < 16; k++) begin
         to_eval(2, 4'b1000);
         tick(); tick();
      end
      match = '0;
      chk("sat_hits_url", hit1(CH_URL), 15);
      chk("sat_pkt", 64'(bus1.pkt_count), 15);
      chk("sat_qual", 64'(bus1.qual_count), 15);
      chk("wide_hits_url", hit0(CH_URL), 16);
      chk("wide_pkt", bus0.pkt_count, 16);
      to_eval(2, 4'b1000);
      clr_stats = 1'b1;
      tick();
      clr_stats = 1'b0;
      chk("clrwin_hits1", hit1(CH_URL), 0);
      chk("clrwin_pkt1", 64'(bus1.pkt_count), 0);
      chk("clrwin_hits0", hit0(CH_URL), 0);
      chk("clrwin_pkt0", bus0.pkt_count, 0);
      chk("clrwin_qual0", bus0.qual_count, 0);
      chk("clrwin_store", bus0.inc_addr, 1);
      tick();
      chk("post_clr_qual0", bus0.qual_count, 1);
      chk("post_clr_qual1", 64'(bus1.qual_count), 1);
      match = '0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/match_controller.md
Name: match_controller

Overview:
- Parametrised successor to the sniffer's packet-match controller.
- Tracks MAC-side packet framing (sop/eop/error/valid/ready) and waits a configurable settle time for the comparator pipeline to finish.
- Scores NUM_CH comparator match flags against runtime-loaded weights and a threshold, then requests a memory store for qualifying packets.
- Maintains saturating per-channel hit counters plus packet, qualified-packet and error statistics, all readable by the Avalon slave.

Parameters:
- NUM_CH, 4, number of comparator channels (bit 0 port, 1 ip, 2 mac, 3 url in the default build).
- CNT_W, 64, width of every statistics counter.
- WEIGHT_W, 4, width of each per-channel weight.
- SETTLE_CYCLES, 4, cycles waited after eop before match flags are sampled; legal range 1..255.
- SCORE_W, WEIGHT_W+$clog2(NUM_CH+1), score and threshold width.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-high.
- match  in  NUM_CH  comparator match flags, held until clear.
- sop  in  1  MAC start of packet.
- eop  in  1  MAC end of packet.
- error  in  1  MAC error.
- valid  in  1  MAC beat valid.
- ready  in  1  MAC beat ready.
- update_req  in  1  Avalon slave requests reconfiguration.
- update_done  in  1  Avalon slave: configuration inputs are stable.
- weights_in  in  NUM_CH*WEIGHT_W  channel i weight is bits [i*WEIGHT_W +: WEIGHT_W].
- threshold_in  in  SCORE_W  qualification threshold.
- clr_stats  in  1  zero all statistics counters.
- cfg_req  out  1  asking the Avalon slave for configuration.
- clear  out  1  clears comparator match flags.
- inc_addr  out  1  one-cycle store/address-increment strobe.
- busy  out  1  high in any state other than IDLE.
- hits  out  NUM_CH*CNT_W  per-channel hit counters.
- pkt_count  out  CNT_W  packets evaluated.
- qual_count  out  CNT_W  packets stored.
- err_count  out  CNT_W  errored or malformed packets.

Behaviour:
- A beat is valid & ready. All outputs are registered, Moore-decoded from the state register.
- Reset (rst sampled high on a clk edge):
  - state goes to LOAD_CFG; cfg_req=1; clear=0; inc_addr=0; busy=1.
  - All counters, latched weights and latched threshold go to 0.
  - rst mid-packet abandons the packet with no counter updates.
- LOAD_CFG:
  - cfg_req=1, clear=1.
  - When update_done is high, latch weights_in and threshold_in in that cycle and go to IDLE.
- IDLE:
  - clear=1, busy=0.
  - update_req has priority over a simultaneous sop beat: go to LOAD_CFG.
  - Otherwise a sop beat goes to COMPARE.
  - A sop beat that also carries eop goes directly to SETTLE.
- COMPARE (clear=0), checked in this priority order:
  - error: go to DROP and increment err_count.
  - A sop beat with no eop (missing eop): go to DROP and increment err_count.
  - eop beat: go to SETTLE and load the settle counter with SETTLE_CYCLES-1.
- SETTLE:
  - Decrement the settle counter each cycle.
  - At 0, go to EVALUATE. Total dwell is exactly SETTLE_CYCLES cycles.
- EVALUATE (single cycle):
  - Sample match.
  - For each set bit, increment hits[i].
  - Increment pkt_count.
  - score = sum of weight[i] over set match bits, computed at full SCORE_W (no overflow).
  - If score >= threshold, go to STORE; otherwise go to IDLE.
  - threshold=0 qualifies every packet.
- STORE:
  - inc_addr=1 for exactly one cycle.
  - Increment qual_count.
  - Go to IDLE.
- DROP:
  - Stay until an eop beat, then go to IDLE.
  - Further errors inside DROP do not increment err_count again.
- Counters:
  - Saturate at all-ones; they never wrap.
  - clr_stats zeroes every counter next cycle and wins over a coincident increment.
  - clr_stats does not change state.
- Weights and threshold change only in LOAD_CFG.
- update_req outside IDLE is ignored; the Avalon slave holds update_req high until cfg_req rises.
- Unused or illegal state encodings recover to IDLE.

Decomposition:
- Shared package sniffer_pkg holds:
  - state enum mc_state_t (LOAD_CFG, IDLE, COMPARE, SETTLE, EVALUATE, STORE, DROP);
  - default channel index constants CH_PORT=0, CH_IP=1, CH_MAC=2, CH_URL=3.
- One sub-module, sat_counter (parameter W; ports clk, rst, clr, inc, count). It is instantiated NUM_CH+3 times.

Test Plan:
- Reset, then update_done with weights {url=4,mac=1,ip=2,port=2} and threshold 4 -> cfg_req falls the cycle after update_done; busy=0 and all counters read 0.
- One 8-beat packet, match=4'b0011 set before eop -> EVALUATE occurs exactly 4 cycles after the eop beat; hits[0]=hits[1]=1; pkt_count=1; inc_addr pulses once; qual_count=1.
- Packet with match=4'b0100 (score 1 < 4) -> pkt_count=2; inc_addr stays 0; qual_count remains 1.
- error asserted mid-packet, then eop two beats later -> err_count=1; no EVALUATE; return to IDLE after eop; pkt_count unchanged.
- Second sop beat before eop -> err_count increments once; DROP until the next eop; then a normal packet is evaluated correctly.
- CNT_W=4 build, 17 packets with match=4'b1000 -> hits[3]=15 (saturated); clr_stats coincident with the final EVALUATE -> all counters read 0.
